// File: rtl/mul8_err_monitor_pkg.sv
// Shared types for the multiplier error monitor: FSM states, operand/product widths, pipeline payload.
package mul8_eval_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // data carries the approximate product in S1 and the absolute error in S2
  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic [PROD_W-1:0] data;
  } stage_t;

endpackage

// File: rtl/mul8_err_monitor_if.sv
// Sample stream from the approximate multiplier into the monitor (valid/ready).
interface mul8_err_monitor_if;
  import mul8_eval_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_a;
  logic [OP_W-1:0]   in_b;
  logic [PROD_W-1:0] in_o;

  modport master (output in_valid, in_a, in_b, in_o, input in_ready);
  modport slave  (input in_valid, in_a, in_b, in_o, output in_ready);

endinterface

// File: rtl/mul8_err_monitor_abs_err.sv
// Combinational exact 8x8 product and |approx - exact|; result always fits 16 bits.
module mul8_abs_err
  import mul8_eval_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic [PROD_W-1:0] o,
  output logic [PROD_W-1:0] err
);

  logic [PROD_W-1:0]      exact;
  logic signed [PROD_W:0] diff;

  assign exact = PROD_W'(a) * PROD_W'(b);
  assign diff  = $signed({1'b0, o}) - $signed({1'b0, exact});
  assign err   = diff[PROD_W] ? PROD_W'(-diff) : PROD_W'(diff);

endmodule

// File: rtl/mul8_err_monitor.sv
// Run-based error statistics (count, error count, saturating sum, worst case) for an approximate multiplier.
// Three-stage pipeline: capture, error compute, accumulate; FSM IDLE/RUN/DRAIN/DONE.
module mul8_err_monitor
  import mul8_eval_pkg::*;
#(
  parameter int CNT_W = 17,
  parameter int SUM_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    cfg_num_samples,
  mul8_err_monitor_if.slave   sif,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    stat_sample_cnt,
  output logic [CNT_W-1:0]    stat_err_cnt,
  output logic [SUM_W-1:0]    stat_sum_abs_err,
  output logic [PROD_W-1:0]   stat_max_err,
  output logic [OP_W-1:0]     stat_max_a,
  output logic [OP_W-1:0]     stat_max_b
);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  n_tgt;
  logic [CNT_W-1:0]  acc_cnt;
  logic              ready;
  logic              accept;
  logic              start_run;
  stage_t            s1, s2;
  logic [PROD_W-1:0] err;
  logic [SUM_W:0]    sum_ext;

  assign sif.in_ready = ready;

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    accept    = 1'b0;
    start_run = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_run = 1'b1;
          state_nxt = (cfg_num_samples == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        busy   = 1'b1;
        ready  = (acc_cnt < n_tgt);
        accept = ready & sif.in_valid;
        if (accept && ((acc_cnt + CNT_W'(1)) == n_tgt)) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!s1.valid && !s2.valid) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  mul8_abs_err u_abs_err (
    .a   (s1.a),
    .b   (s1.b),
    .o   (s1.data),
    .err (err)
  );

  assign sum_ext = {1'b0, stat_sum_abs_err} + (SUM_W+1)'(s2.data);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      n_tgt            <= '0;
      acc_cnt          <= '0;
      s1               <= '0;
      s2               <= '0;
      stat_sample_cnt  <= '0;
      stat_err_cnt     <= '0;
      stat_sum_abs_err <= '0;
      stat_max_err     <= '0;
      stat_max_a       <= '0;
      stat_max_b       <= '0;
    end else begin
      state <= state_nxt;

      if (start_run) begin
        n_tgt   <= cfg_num_samples;
        acc_cnt <= '0;
      end else if (accept) begin
        acc_cnt <= acc_cnt + CNT_W'(1);
      end

      s1 <= '{valid: accept, a: sif.in_a, b: sif.in_b, data: sif.in_o};
      s2 <= '{valid: s1.valid, a: s1.a, b: s1.b, data: err};

      // pipeline is empty in IDLE, so clearing and accumulating never collide
      if (start_run) begin
        stat_sample_cnt  <= '0;
        stat_err_cnt     <= '0;
        stat_sum_abs_err <= '0;
        stat_max_err     <= '0;
        stat_max_a       <= '0;
        stat_max_b       <= '0;
      end else if (s2.valid) begin
        stat_sample_cnt  <= stat_sample_cnt + CNT_W'(1);
        stat_err_cnt     <= stat_err_cnt + CNT_W'(s2.data != '0);
        stat_sum_abs_err <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
        if (s2.data > stat_max_err) begin
          stat_max_err <= s2.data;
          stat_max_a   <= s2.a;
          stat_max_b   <= s2.b;
        end
      end
    end
  end

endmodule
